// File: rtl/game_pkg.sv
// Shared types and screen constants for the game's video path.
// Used by the block position generator and the block renderer.
package game_pkg;

  typedef logic [23:0] rgb_t;  // {R[7:0], G[7:0], B[7:0]}

  localparam int unsigned H_MAX = 639;
  localparam int unsigned V_MAX = 479;

  // One count per visible pixel of a 640x480 frame.
  localparam logic [18:0] PIX_PER_FRAME = 19'd307200;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } render_state_t;

endpackage

// File: rtl/block_renderer_if.sv
// Pixel stream between the VGA controller (master) and the block renderer (slave).
interface block_renderer_if;

  // Valid-only stream, no back-pressure: a pixel is transferred on every Clk
  // edge where PixValid is high; PixOutValid marks the matching colour output,
  // which trails its pixel by exactly two Clk cycles.
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       PixValid;
  logic [7:0] Red;
  logic [7:0] Green;
  logic [7:0] Blue;
  logic       PixOutValid;

  modport master (
    output DrawX, DrawY, PixValid,
    input  Red, Green, Blue, PixOutValid
  );

  modport slave (
    input  DrawX, DrawY, PixValid,
    output Red, Green, Blue, PixOutValid
  );

endinterface

// File: rtl/block_renderer_rise_detect.sv
// Rising-edge detector for a level sampled as data on clk: one flop plus an AND.
// A level that is already high when reset releases still yields one edge.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic fq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq <= 1'b0;
    end else begin
      fq <= d;
    end
  end

  assign rise = d & ~fq;

endmodule

// File: rtl/block_renderer.sv
// Draws a solid square block over a background from a two-stage pixel pipeline,
// with geometry latched once per frame and a per-frame count of block pixels.
module block_renderer #(
  parameter game_pkg::rgb_t BLOCK_COLOR = 24'hFF5500,
  parameter game_pkg::rgb_t BG_COLOR    = 24'h000000,
  parameter int unsigned    H_MAX       = game_pkg::H_MAX,
  parameter int unsigned    V_MAX       = game_pkg::V_MAX
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [9:0]              BlockX,
  input  logic [9:0]              BlockY,
  input  logic [9:0]              BlockS,
  block_renderer_if.slave         pix,
  output logic [18:0]             BlockPixCount,
  output logic                    FrameDone,
  output game_pkg::render_state_t state_dbg
);

  import game_pkg::*;

  localparam logic [10:0] H_LIM = 11'(H_MAX);
  localparam logic [10:0] V_LIM = 11'(V_MAX);

  render_state_t state_q;
  render_state_t state_d;
  logic          frame_edge;

  logic [9:0]    sx_q, sy_q, ss_q;
  logic [9:0]    dx1_q, dy1_q;
  logic          v1_q;
  rgb_t          rgb_q;
  logic          out_valid_q;
  logic [18:0]   acc_q;

  logic [10:0]   dx_e, dy_e, sx_e, sy_e, ss_e;
  logic          hit;
  logic          pix_hit;

  rise_detect u_frame_rise (
    .clk   (Clk),
    .rst_n (Reset),
    .d     (frame_clk),
    .rise  (frame_edge)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Only reset returns the renderer to FILL; every frame edge lands in RUN.
  always_comb begin
    state_d = state_q;
    if (frame_edge) begin
      state_d = RUN;
    end
  end

  assign state_dbg = state_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sx_q <= '0;
      sy_q <= '0;
      ss_q <= '0;
    end else if (frame_edge) begin
      sx_q <= BlockX;
      sy_q <= BlockY;
      ss_q <= BlockS;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dx1_q <= '0;
      dy1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      dx1_q <= pix.DrawX;
      dy1_q <= pix.DrawY;
      v1_q  <= pix.PixValid;
    end
  end

  // One extra bit keeps centre-minus-size from wrapping near the screen origin.
  always_comb begin
    dx_e = {1'b0, dx1_q};
    dy_e = {1'b0, dy1_q};
    sx_e = {1'b0, sx_q};
    sy_e = {1'b0, sy_q};
    ss_e = {1'b0, ss_q};
    hit  = (dx_e + ss_e >= sx_e) && (dx_e <= sx_e + ss_e) &&
           (dy_e + ss_e >= sy_e) && (dy_e <= sy_e + ss_e) &&
           (dx_e <= H_LIM) && (dy_e <= V_LIM) &&
           (state_q == RUN);
  end

  assign pix_hit = v1_q & hit;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (!v1_q) begin
        rgb_q <= '0;
      end else if (hit) begin
        rgb_q <= BLOCK_COLOR;
      end else begin
        rgb_q <= BG_COLOR;
      end
    end
  end

  assign pix.Red         = rgb_q[23:16];
  assign pix.Green       = rgb_q[15:8];
  assign pix.Blue        = rgb_q[7:0];
  assign pix.PixOutValid = out_valid_q;

  // A hit landing on the edge cycle belongs to the frame that is starting.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q         <= '0;
      BlockPixCount <= '0;
      FrameDone     <= 1'b0;
    end else begin
      FrameDone <= frame_edge;
      if (frame_edge) begin
        BlockPixCount <= acc_q;
        acc_q         <= {18'd0, pix_hit};
      end else if (pix_hit && (acc_q != PIX_PER_FRAME)) begin
        acc_q <= acc_q + 19'd1;
      end
    end
  end

endmodule

// File: tb/tb_block_renderer.sv
// Directed bench for block_renderer: windowed frame scans, frame-edge publishing,
// corner and screen-edge clipping, geometry shadowing, latency and mid-frame reset.
module tb_block_renderer;

  import game_pkg::*;

  localparam rgb_t BLK = 24'hFF5500;
  localparam rgb_t BG  = 24'h000000;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          frame_clk = 1'b0;
  logic [9:0]    BlockX = '0;
  logic [9:0]    BlockY = '0;
  logic [9:0]    BlockS = '0;
  logic [18:0]   BlockPixCount;
  logic          FrameDone;
  render_state_t state_dbg;

  block_renderer_if pix ();

  block_renderer dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .BlockX        (BlockX),
    .BlockY        (BlockY),
    .BlockS        (BlockS),
    .pix           (pix),
    .BlockPixCount (BlockPixCount),
    .FrameDone     (FrameDone),
    .state_dbg     (state_dbg)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  logic [23:0] cap [int];
  logic        capv [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] rgb_now();
    return {pix.Red, pix.Green, pix.Blue};
  endfunction

  task automatic drive(input int x, input int y, input logic v);
    pix.DrawX    = 10'(x);
    pix.DrawY    = 10'(y);
    pix.PixValid = v;
  endtask

  // Raster-scan a window; outputs are captured two negedges after each pixel.
  task automatic scan(input int x0, input int x1, input int y0, input int y1);
    int  p1x = 0, p1y = 0, p2x = 0, p2y = 0;
    bit  p1v = 1'b0, p2v = 1'b0;
    cap.delete();
    capv.delete();
    for (int y = y0; y <= y1; y++) begin
      for (int x = x0; x <= x1; x++) begin
        @(negedge Clk);
        if (p2v) begin
          cap[p2x * 1024 + p2y]  = rgb_now();
          capv[p2x * 1024 + p2y] = pix.PixOutValid;
        end
        p2x = p1x; p2y = p1y; p2v = p1v;
        p1x = x;   p1y = y;   p1v = 1'b1;
        drive(x, y, 1'b1);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (p2v) begin
        cap[p2x * 1024 + p2y]  = rgb_now();
        capv[p2x * 1024 + p2y] = pix.PixOutValid;
      end
      p2x = p1x; p2y = p1y; p2v = p1v;
      p1v = 1'b0;
      drive(0, 0, 1'b0);
    end
  endtask

  task automatic chk_pix(input string tag, input int x, input int y, input logic [23:0] e);
    int k = x * 1024 + y;
    if (!cap.exists(k)) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: observed no output expected %0h", tag, e);
    end else begin
      chk({tag, "_valid"}, 32'(capv[k]), 32'd1);
      chk(tag, 32'(cap[k]), 32'(e));
    end
  endtask

  task automatic frame_edge(input logic [18:0] exp_cnt, input string tag);
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    chk({tag, "_done"}, 32'(FrameDone), 32'd1);
    chk({tag, "_count"}, 32'(BlockPixCount), 32'(exp_cnt));
    chk({tag, "_state"}, 32'(state_dbg), 32'(RUN));
    frame_clk = 1'b0;
    @(negedge Clk);
    chk({tag, "_done_low"}, 32'(FrameDone), 32'd0);
  endtask

  initial begin
    // Reset held with a valid pixel presented
    drive(440, 120, 1'b1);
    BlockX = 10'd440; BlockY = 10'd120; BlockS = 10'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("rst_rgb", 32'(rgb_now()), 32'd0);
      chk("rst_valid", 32'(pix.PixOutValid), 32'd0);
      chk("rst_count", 32'(BlockPixCount), 32'd0);
      chk("rst_done", 32'(FrameDone), 32'd0);
      chk("rst_state", 32'(state_dbg), 32'(FILL));
    end
    Reset = 1'b1;

    // FILL: pixel inside the would-be block still renders background
    @(negedge Clk);
    @(negedge Clk);
    chk("fill_valid", 32'(pix.PixOutValid), 32'd1);
    chk("fill_rgb", 32'(rgb_now()), 32'(BG));
    chk("fill_state", 32'(state_dbg), 32'(FILL));
    drive(0, 0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    chk("blank_valid", 32'(pix.PixOutValid), 32'd0);

    // First edge latches (440,120,8) and publishes the FILL count of 0
    frame_edge(19'd0, "edge1");
    BlockX = 10'd100;  // must not take effect until the next edge
    scan(420, 460, 100, 140);
    chk_pix("a_432_112", 432, 112, BLK);
    chk_pix("a_448_128", 448, 128, BLK);
    chk_pix("a_431_120", 431, 120, BG);
    chk_pix("a_449_120", 449, 120, BG);
    chk_pix("a_440_111", 440, 111, BG);

    // Second edge: 17x17 block; geometry moves to X=100
    frame_edge(19'd289, "edge2");
    BlockX = 10'd3; BlockY = 10'd2; BlockS = 10'd8;
    scan(80, 120, 100, 140);
    chk_pix("b_92_112", 92, 112, BLK);
    chk_pix("b_108_128", 108, 128, BLK);
    chk_pix("b_91_112", 91, 112, BG);
    chk_pix("b_109_120", 109, 120, BG);

    // Corner block (3,2,8): x 0..11, y 0..10
    frame_edge(19'd289, "edge3");
    BlockX = 10'd636; BlockY = 10'd475; BlockS = 10'd8;
    scan(0, 15, 0, 15);
    chk_pix("c_0_0", 0, 0, BLK);
    chk_pix("c_11_10", 11, 10, BLK);
    chk_pix("c_12_0", 12, 0, BG);
    chk_pix("c_0_11", 0, 11, BG);

    // Block overhanging the bottom-right screen edge: x 628..639, y 467..479
    frame_edge(19'd132, "edge4");
    BlockX = 10'd440; BlockY = 10'd120; BlockS = 10'd8;
    scan(620, 660, 460, 490);
    chk_pix("d_639_479", 639, 479, BLK);
    chk_pix("d_628_467", 628, 467, BLK);
    chk_pix("d_640_479", 640, 479, BG);
    chk_pix("d_639_480", 639, 480, BG);
    chk_pix("d_627_467", 627, 467, BG);

    // Clipped count 12x13, geometry back to (440,120,8)
    frame_edge(19'd156, "edge5");

    // Single valid pixel: output appears exactly two cycles later
    @(negedge Clk);
    drive(440, 120, 1'b1);
    @(negedge Clk);
    drive(0, 0, 1'b0);
    chk("lat_t1_valid", 32'(pix.PixOutValid), 32'd0);
    @(negedge Clk);
    chk("lat_t2_valid", 32'(pix.PixOutValid), 32'd1);
    chk("lat_t2_rgb", 32'(rgb_now()), 32'(BLK));
    @(negedge Clk);
    chk("lat_t3_valid", 32'(pix.PixOutValid), 32'd0);
    chk("lat_t3_rgb", 32'(rgb_now()), 32'd0);

    // Mid-frame reset at line 200
    drive(300, 200, 1'b1);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("mrst_rgb", 32'(rgb_now()), 32'd0);
    chk("mrst_valid", 32'(pix.PixOutValid), 32'd0);
    chk("mrst_count", 32'(BlockPixCount), 32'd0);
    chk("mrst_state", 32'(state_dbg), 32'(FILL));
    @(negedge Clk);
    Reset = 1'b1;
    drive(440, 120, 1'b1);
    @(negedge Clk);
    drive(0, 0, 1'b0);
    @(negedge Clk);
    chk("mrst_fill_valid", 32'(pix.PixOutValid), 32'd1);
    chk("mrst_fill_rgb", 32'(rgb_now()), 32'(BG));
    @(negedge Clk);

    frame_edge(19'd0, "edge6");
    scan(420, 460, 100, 140);
    chk_pix("e_440_120", 440, 120, BLK);
    frame_edge(19'd289, "edge7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/block_renderer.md
Name: block_renderer

Overview:
- Consumer end of the block position interface: takes BlockX/BlockY/BlockS from the block position generator and the VGA controller's DrawX/DrawY stream, and produces per-pixel RGB.
- Latches block geometry once per frame on the frame_clk rising edge, so a frame never tears.
- Runs a 2-stage pixel pipeline.
- Publishes a per-frame count of block pixels drawn, which the game logic reads back.

Parameters:
- BLOCK_COLOR, 24'hFF5500, RGB {R,G,B} for pixels inside the block
- BG_COLOR, 24'h000000, RGB for pixels outside the block, and for all pixels before the first frame edge
- H_MAX, 639, largest valid DrawX
- V_MAX, 479, largest valid DrawY

Ports:
- Clk  in  1  pixel clock; sole clock
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame strobe from the VGA controller (vsync-derived); sampled as data on Clk, never used as a clock
- BlockX  in  10  block centre X
- BlockY  in  10  block centre Y
- BlockS  in  10  block half-size
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- PixValid  in  1  DrawX/DrawY is a visible pixel this cycle
- Red  out  8  pixel colour, red
- Green  out  8  pixel colour, green
- Blue  out  8  pixel colour, blue
- PixOutValid  out  1  Red/Green/Blue correspond to a valid input pixel
- BlockPixCount  out  19  number of block pixels drawn in the previous frame (max 307200)
- FrameDone  out  1  one-cycle pulse when BlockPixCount updates

Behaviour:
- Reset (asserted low, asynchronous) sets all registers to 0:
  - Red/Green/Blue = 0, PixOutValid = 0, BlockPixCount = 0, FrameDone = 0.
  - Shadow geometry = 0, frame_clk sample register = 0, state = FILL.
- Frame edge detection:
  - fq <= frame_clk every Clk.
  - edge = frame_clk & ~fq.
  - A constant-high frame_clk after reset produces exactly one edge.
- FSM states:
  - FILL: no geometry latched yet. Every valid pixel outputs BG_COLOR; the hit accumulator is held at 0.
  - RUN: normal operation.
- FSM transitions:
  - FILL -> RUN on the first edge.
  - RUN -> RUN on every subsequent edge.
  - Any state -> FILL only on Reset, including mid-frame.
- On an edge, in the same cycle:
  - Shadow SX/SY/SS <= BlockX/BlockY/BlockS.
  - BlockPixCount <= acc. In FILL, acc is 0.
  - FrameDone <= 1 for one cycle.
  - acc <= 0, plus 1 if stage 2 registers a hit that cycle.
- Pipeline, stage 1 (cycle t+1): register DrawX, DrawY, PixValid.
- Pipeline, stage 2 (cycle t+2): compute hit from the stage-1 values and the shadow geometry as they stand in cycle t+1; register colour and PixOutValid.
- Latency: exactly 2 Clk cycles from DrawX/DrawY/PixValid to Red/Green/Blue/PixOutValid. No stalls, one pixel per cycle.
- Hit test uses 11-bit unsigned arithmetic with no clamp, so there is no underflow when SX < SS:
  - {0,DX} + SS >= {0,SX}
  - {0,DX} <= {0,SX} + SS
  - the same two conditions on Y
  - DX <= H_MAX and DY <= V_MAX
  - state == RUN
- Block shape: a square of side 2*SS+1 centred at (SX,SY). SS = 0 gives a single pixel.
- Output colour:
  - PixValid low in stage 1: PixOutValid = 0 and RGB = 0 (blanking).
  - Valid pixel and hit: BLOCK_COLOR, and acc increments.
  - Valid pixel, no hit: BG_COLOR.
- acc saturates at 307200 and does not wrap.
- Geometry changes on BlockX/BlockY/BlockS between edges have no effect until the next edge.
- An edge coinciding with a hit: the hit counts toward the new frame's acc, as in the edge rule above.

Decomposition:
- Shared package (game_pkg):
  - typedef rgb_t (24-bit {R,G,B})
  - constants H_MAX and V_MAX
  - constant PIX_PER_FRAME = 307200
  - enum render_state_t {FILL, RUN}
- One natural sub-module: rise_detect (1-flop sampler plus AND). The position generator will reuse it once keyboard-driven motion lands.

Test Plan:
- Reset held low 5 cycles with PixValid=1 -> Red/Green/Blue=0, PixOutValid=0, BlockPixCount=0, FrameDone=0 throughout.
- No frame edge; BlockX=440, BlockY=120, BlockS=8; DrawX/DrawY at (440,120), PixValid=1 -> BG_COLOR 2 cycles later (FILL state).
- Edge with X=440, Y=120, S=8; scan a full 640x480 frame; second edge -> FrameDone pulse, BlockPixCount=289 (17x17). Pixel (432,112) = BLOCK_COLOR; pixels (431,120) and (449,120) = BG_COLOR.
- Corner underflow: latch X=3, Y=2, S=8; scan a frame -> (0,0) is BLOCK_COLOR; BlockPixCount=12*11=132.
- Change BlockX to 100 mid-frame -> rendering keeps using X=440 until the next edge, then moves. A single pixel with PixValid toggled shows exactly 2-cycle latency.
- Assert Reset at line 200 mid-frame, release it -> FILL state, next edge publishes BlockPixCount=0, the edge after that publishes 289.
